// File: rtl/ev_cmd_sequencer.sv
// EV command sequencer: one-entry command holding register, DWELL-timed operation FSM and
// an 8-cycle-slot multiplexed accel/brake nibble. Define RAMP_EN to ramp accel_cur by 1 per boundary.
module ev_cmd_sequencer #(
  parameter int unsigned DWELL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_accel,
  input  logic [3:0] cmd_brake,
  input  logic       cmd_power,
  input  logic       fault_in,
  input  logic       power_status_in,
  output logic [2:0] op_select,
  output logic       power_on,
  output logic [3:0] ab_data,
  output logic       ab_phase,
  output logic       round_done,
  output logic       link_err
);

  // IDLE takes the spare code 110 so every operation state can carry its op code directly
  typedef enum logic [2:0] {
    ST_POWER  = 3'b000,
    ST_HDL    = 3'b001,
    ST_HORN   = 3'b010,
    ST_IND    = 3'b011,
    ST_SPEED  = 3'b100,
    ST_PWM    = 3'b101,
    ST_IDLE   = 3'b110,
    ST_STATUS = 3'b111
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] slot_q, slot_d;
  logic       ab_phase_q, ab_phase_d;
  logic [3:0] ab_data_q, ab_data_d;
  logic       hold_valid_q, hold_valid_d;
  logic [3:0] hold_accel_q, hold_accel_d;
  logic [3:0] hold_brake_q, hold_brake_d;
  logic       hold_power_q, hold_power_d;
  logic       power_on_q, power_on_d;
  logic       link_err_q, link_err_d;
  logic [3:0] accel_cur_q, accel_cur_d;
  logic [3:0] accel_tgt_q, accel_tgt_d;
  logic [3:0] brake_cur_q, brake_cur_d;

  logic accept, apply, dwell_last, slot_wrap, accel_bnd;

  assign accept     = cmd_valid && !hold_valid_q;
  assign dwell_last = (dwell_q == DWELL_LAST);
  assign apply      = (state_q == ST_POWER) && (dwell_q == 8'd0) && hold_valid_q;
  assign slot_wrap  = (slot_q == 3'd7);
  assign accel_bnd  = slot_wrap && ab_phase_q;

  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    slot_d       = slot_q + 3'd1;
    ab_phase_d   = ab_phase_q;
    ab_data_d    = ab_data_q;
    hold_valid_d = hold_valid_q;
    hold_accel_d = hold_accel_q;
    hold_brake_d = hold_brake_q;
    hold_power_d = hold_power_q;
    power_on_d   = power_on_q;
    link_err_d   = link_err_q;
    accel_cur_d  = accel_cur_q;
    accel_tgt_d  = accel_tgt_q;
    brake_cur_d  = brake_cur_q;

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_accel_d = cmd_accel;
      hold_brake_d = cmd_brake;
      hold_power_d = cmd_power;
    end

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_POWER;
        dwell_d = 8'd0;
      end
    end else if (dwell_last) begin
      dwell_d = 8'd0;
      case (state_q)
        ST_POWER:  state_d = power_on_q ? ST_HDL : ST_POWER;
        ST_HDL:    state_d = ST_HORN;
        ST_HORN:   state_d = ST_IND;
        ST_IND:    state_d = ST_SPEED;
        ST_SPEED:  state_d = ST_PWM;
        ST_PWM:    state_d = ST_STATUS;
        ST_STATUS: state_d = ST_POWER;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      dwell_d = dwell_q + 8'd1;
    end

    if (state_q == ST_POWER && dwell_last && power_on_q && !power_status_in)
      link_err_d = 1'b1;

    // Accelerator only moves on the brake->accel phase boundary; fault overrides the target
    if (accel_bnd) begin
      if (!power_on_q) begin
        accel_cur_d = 4'd0;
        brake_cur_d = 4'd0;
      end else if (fault_in) begin
        accel_cur_d = (accel_cur_q == 4'd0) ? 4'd0 : accel_cur_q - 4'd1;
      end else begin
`ifdef RAMP_EN
        if (accel_cur_q < accel_tgt_q)
          accel_cur_d = accel_cur_q + 4'd1;
        else if (accel_cur_q > accel_tgt_q)
          accel_cur_d = accel_cur_q - 4'd1;
`else
        accel_cur_d = accel_tgt_q;
`endif
      end
    end

    if (apply) begin
      hold_valid_d = 1'b0;
      power_on_d   = hold_power_q;
      brake_cur_d  = hold_brake_q;
      accel_tgt_d  = hold_accel_q;
      link_err_d   = 1'b0;
    end

    // The nibble shows the freshly updated value for the slot it is entering
    if (slot_wrap) begin
      ab_phase_d = ~ab_phase_q;
      ab_data_d  = ab_phase_q ? accel_cur_d : brake_cur_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dwell_q      <= 8'd0;
      slot_q       <= 3'd0;
      ab_phase_q   <= 1'b0;
      ab_data_q    <= 4'd0;
      hold_valid_q <= 1'b0;
      hold_accel_q <= 4'd0;
      hold_brake_q <= 4'd0;
      hold_power_q <= 1'b0;
      power_on_q   <= 1'b0;
      link_err_q   <= 1'b0;
      accel_cur_q  <= 4'd0;
      accel_tgt_q  <= 4'd0;
      brake_cur_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      slot_q       <= slot_d;
      ab_phase_q   <= ab_phase_d;
      ab_data_q    <= ab_data_d;
      hold_valid_q <= hold_valid_d;
      hold_accel_q <= hold_accel_d;
      hold_brake_q <= hold_brake_d;
      hold_power_q <= hold_power_d;
      power_on_q   <= power_on_d;
      link_err_q   <= link_err_d;
      accel_cur_q  <= accel_cur_d;
      accel_tgt_q  <= accel_tgt_d;
      brake_cur_q  <= brake_cur_d;
    end
  end

  assign cmd_ready  = !hold_valid_q;
  assign op_select  = (state_q == ST_IDLE) ? 3'b000 : state_q;
  assign power_on   = power_on_q;
  assign ab_data    = ab_data_q;
  assign ab_phase   = ab_phase_q;
  assign round_done = (state_q == ST_STATUS) && dwell_last;
  assign link_err   = link_err_q;

endmodule
